// File: rtl/inst_fetch_unit_if.sv
// Instruction bus between the fetch unit (master) and the instruction SRAM (slave):
// separate address and data handshakes, in-order returns.
interface inst_fetch_unit_if #(parameter int ADDR_WIDTH = 32);
    logic                  inst_req;
    logic [ADDR_WIDTH-1:0] inst_addr;
    logic                  inst_addr_ok;
    logic [31:0]           inst_rdata;
    logic                  inst_data_ok;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_rdata, inst_data_ok
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_rdata, inst_data_ok
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Fetch PC owner: issues one outstanding instruction request at a time, buffers a single
// returned word behind a stalled decode, and applies branch (delayed) and flush (immediate) redirects.
module inst_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC00000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    inst_fetch_unit_if.master     bus,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [31:0]           inst,
    output logic                  inst_valid
);
    localparam logic [ADDR_WIDTH-1:0] WORD  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] DWORD = ADDR_WIDTH'(8);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_nxt;
    logic [ADDR_WIDTH-1:0] pend_addr, pend_addr_nxt;
    logic [ADDR_WIDTH-1:0] br_target, br_target_nxt;
    logic [ADDR_WIDTH-1:0] buf_addr, buf_addr_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [31:0]           buf_inst, buf_inst_nxt, inst_nxt;
    logic                  owed, owed_nxt;
    logic                  br_pend, br_pend_nxt;
    logic                  buf_valid, buf_valid_nxt;
    logic                  valid_nxt;

    logic                  acc, consume, br_take, out_free, kill, dv;
    logic [ADDR_WIDTH-1:0] ds_pc;

    assign acc      = (state == REQ) && bus.inst_addr_ok;
    assign consume  = inst_valid && !stall;
    assign br_take  = consume && branch_flag;
    assign ds_pc    = addr + WORD;
    assign out_free = !inst_valid || consume;
    // The request in flight is B+8 when a branch at B is consumed: its data must never reach decode.
    assign kill     = br_take && (state == WAIT) && owed && (pend_addr == addr + DWORD);
    assign dv       = bus.inst_data_ok && owed && (state == WAIT) && !kill;

    assign bus.inst_req  = (state == REQ);
    assign bus.inst_addr = {fetch_pc[ADDR_WIDTH-1:2], 2'b00};

    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        pend_addr_nxt = pend_addr;
        br_target_nxt = br_target;
        br_pend_nxt   = br_pend;
        buf_valid_nxt = buf_valid;
        buf_addr_nxt  = buf_addr;
        buf_inst_nxt  = buf_inst;
        addr_nxt      = addr;
        inst_nxt      = inst;
        valid_nxt     = inst_valid;
        owed_nxt      = (owed && !bus.inst_data_ok) || acc;

        if (acc) begin
            pend_addr_nxt = fetch_pc;
            fetch_pc_nxt  = br_pend ? br_target : fetch_pc + WORD;
            br_pend_nxt   = 1'b0;
        end

        if (out_free) begin
            if (buf_valid) begin
                addr_nxt      = buf_addr;
                inst_nxt      = buf_inst;
                valid_nxt     = 1'b1;
                buf_valid_nxt = dv;
                if (dv) begin
                    buf_addr_nxt = pend_addr;
                    buf_inst_nxt = bus.inst_rdata;
                end
            end else if (dv) begin
                addr_nxt  = pend_addr;
                inst_nxt  = bus.inst_rdata;
                valid_nxt = 1'b1;
            end else begin
                valid_nxt = 1'b0;
            end
        end else if (dv) begin
            buf_valid_nxt = 1'b1;
            buf_addr_nxt  = pend_addr;
            buf_inst_nxt  = bus.inst_rdata;
        end

        // Delay slot not yet accepted: redirect on its acceptance; otherwise redirect now.
        if (br_take) begin
            if (fetch_pc == ds_pc && !acc) begin
                br_pend_nxt   = 1'b1;
                br_target_nxt = branch_addr;
            end else begin
                fetch_pc_nxt = branch_addr;
            end
        end

        unique case (state)
            IDLE:  state_nxt = REQ;
            REQ:   if (acc) state_nxt = (br_take && fetch_pc != ds_pc) ? DRAIN : WAIT;
            WAIT: begin
                if (kill && !bus.inst_data_ok)  state_nxt = DRAIN;
                else if (owed_nxt || buf_valid_nxt) state_nxt = WAIT;
                else                            state_nxt = REQ;
            end
            DRAIN: if (bus.inst_data_ok) state_nxt = buf_valid_nxt ? WAIT : REQ;
            default: state_nxt = IDLE;
        endcase

        if (flush) begin
            valid_nxt     = 1'b0;
            buf_valid_nxt = 1'b0;
            br_pend_nxt   = 1'b0;
            fetch_pc_nxt  = flush_pc;
            unique case (state)
                IDLE:    state_nxt = REQ;
                REQ:     state_nxt = acc ? DRAIN : REQ;
                WAIT:    state_nxt = (owed && !bus.inst_data_ok) ? DRAIN : REQ;
                DRAIN:   state_nxt = bus.inst_data_ok ? REQ : DRAIN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            pend_addr  <= '0;
            br_target  <= '0;
            br_pend    <= 1'b0;
            owed       <= 1'b0;
            buf_valid  <= 1'b0;
            buf_addr   <= '0;
            buf_inst   <= '0;
            addr       <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            pend_addr  <= pend_addr_nxt;
            br_target  <= br_target_nxt;
            br_pend    <= br_pend_nxt;
            owed       <= owed_nxt;
            buf_valid  <= buf_valid_nxt;
            buf_addr   <= buf_addr_nxt;
            buf_inst   <= buf_inst_nxt;
            addr       <= addr_nxt;
            inst       <= inst_nxt;
            inst_valid <= valid_nxt;
        end
    end
endmodule
